// File: rtl/lfsr_rc_reverse.sv
// lfsr_rc_reverse: seeks the 6-bit XNOR LFSR forward to c_ROUNDS, then streams
// c_ROUNDS..c_1 backward over a valid/ready interface for the inverse rounds.
module lfsr_rc_reverse #(
    parameter int ROUNDS = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic [5:0] rc_out,
    output logic       rc_valid,
    input  logic       rc_ready,
    output logic [5:0] rc_idx,
    output logic       rc_last,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, SEEK, EMIT, DONE} state_t;

    localparam logic [5:0] LAST_CNT  = 6'(ROUNDS - 1);
    localparam logic [5:0] FIRST_IDX = 6'(ROUNDS);

    state_t     r_state, w_state_nx;
    logic [5:0] r_s, w_s_nx;
    logic [5:0] r_cnt, w_cnt_nx;
    logic [5:0] r_idx, w_idx_nx;

    function automatic logic [5:0] fwd(input logic [5:0] x);
        return {x[4:0], ~(x[5] ^ x[4])};
    endfunction

    function automatic logic [5:0] inv(input logic [5:0] x);
        return {~(x[0] ^ x[5]), x[5:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        case (r_state)
            IDLE: if (start) begin
                w_state_nx = SEEK;
                w_s_nx     = '0;
                w_cnt_nx   = '0;
            end
            SEEK: begin
                w_s_nx   = fwd(r_s);
                w_cnt_nx = r_cnt + 6'd1;
                if (r_cnt == LAST_CNT) begin
                    w_state_nx = EMIT;
                    w_idx_nx   = FIRST_IDX;
                end
            end
            EMIT: if (rc_ready) begin
                if (r_idx == 6'd1) begin
                    w_state_nx = DONE;
                    w_idx_nx   = '0;
                end else begin
                    w_s_nx   = inv(r_s);
                    w_idx_nx = r_idx - 6'd1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs decode registered state only; rc_ready never reaches them.
    assign busy     = (r_state == SEEK) || (r_state == EMIT);
    assign rc_valid = r_state == EMIT;
    assign rc_out   = rc_valid ? r_s : 6'd0;
    assign rc_idx   = rc_valid ? r_idx : 6'd0;
    assign rc_last  = rc_valid && (r_idx == 6'd1);
    assign done     = r_state == DONE;
endmodule

// File: tb/tb_lfsr_rc_reverse.sv
// tb_lfsr_rc_reverse: directed checks of four lfsr_rc_reverse instances
// (ROUNDS = 6, 48, 1, 63) sharing clock, reset, start and rc_ready.
module tb_lfsr_rc_reverse;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic rc_ready = 1'b0;
    logic [3:0]      busy_v, valid_v, last_v, done_v;
    logic [3:0][5:0] out_v, idx_v;

    int n_tests = 0;
    int n_fail = 0;

    logic [5:0] exp6 [6] = '{6'b111110, 6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001};
    logic [5:0] model [64];

    logic [5:0] cap_v[$];
    logic [5:0] cap_i[$];
    logic       cap_l[$];
    int         cap_first;
    logic       cap_done;

    always #5 clk = ~clk;

    lfsr_rc_reverse #(.ROUNDS(6)) u_r6 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_v[0]), .rc_out(out_v[0]),
        .rc_valid(valid_v[0]), .rc_ready(rc_ready), .rc_idx(idx_v[0]), .rc_last(last_v[0]), .done(done_v[0])
    );
    lfsr_rc_reverse #(.ROUNDS(48)) u_r48 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_v[1]), .rc_out(out_v[1]),
        .rc_valid(valid_v[1]), .rc_ready(rc_ready), .rc_idx(idx_v[1]), .rc_last(last_v[1]), .done(done_v[1])
    );
    lfsr_rc_reverse #(.ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_v[2]), .rc_out(out_v[2]),
        .rc_valid(valid_v[2]), .rc_ready(rc_ready), .rc_idx(idx_v[2]), .rc_last(last_v[2]), .done(done_v[2])
    );
    lfsr_rc_reverse #(.ROUNDS(63)) u_r63 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_v[3]), .rc_out(out_v[3]),
        .rc_valid(valid_v[3]), .rc_ready(rc_ready), .rc_idx(idx_v[3]), .rc_last(last_v[3]), .done(done_v[3])
    );

    function automatic logic [5:0] fwd(input logic [5:0] x);
        return {x[4:0], ~(x[5] ^ x[4])};
    endfunction

    function automatic logic [5:0] inv(input logic [5:0] x);
        return {~(x[0] ^ x[5]), x[5:1]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        start = 1'b0;
        rc_ready = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic start_seq;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records every accepted beat of instance d until its done pulse or max_cyc cycles.
    task automatic collect(input int d, input int max_cyc);
        cap_v.delete();
        cap_i.delete();
        cap_l.delete();
        cap_first = -1;
        cap_done = 1'b0;
        rc_ready = 1'b1;
        for (int c = 0; c < max_cyc && !cap_done; c++) begin
            if (valid_v[d]) begin
                if (cap_first < 0) cap_first = c;
                cap_v.push_back(out_v[d]);
                cap_i.push_back(idx_v[d]);
                cap_l.push_back(last_v[d]);
            end
            if (done_v[d]) cap_done = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        rc_ready = 1'b0;
        tick();
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if ({busy_v[d], valid_v[d], last_v[d], done_v[d], out_v[d], idx_v[d]} !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d got %h expected 0000", d,
                         {busy_v[d], valid_v[d], last_v[d], done_v[d], out_v[d], idx_v[d]});
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_stream;
        do_reset();
        rc_ready = 1'b1;
        start_seq();
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if ({busy_v[0], valid_v[0], out_v[0], idx_v[0]} !== 14'b10_000000_000000) begin
                n_fail++;
                $display("FAIL stream_seek cycle %0d got busy=%b valid=%b out=%b idx=%0d expected busy=1 valid=0 out=0 idx=0",
                         i, busy_v[0], valid_v[0], out_v[0], idx_v[0]);
            end
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({valid_v[0], out_v[0], idx_v[0], last_v[0]} !== {1'b1, exp6[k], 6'(6 - k), k == 5}) begin
                n_fail++;
                $display("FAIL stream_beat %0d got valid=%b out=%b idx=%0d last=%b expected valid=1 out=%b idx=%0d last=%b",
                         k, valid_v[0], out_v[0], idx_v[0], last_v[0], exp6[k], 6 - k, k == 5);
            end
            tick();
        end
        n_tests++;
        if ({done_v[0], valid_v[0], busy_v[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL stream_done got done/valid/busy=%b expected 100", {done_v[0], valid_v[0], busy_v[0]});
        end
        tick();
        n_tests++;
        if ({done_v[0], busy_v[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL stream_idle got done/busy=%b expected 00", {done_v[0], busy_v[0]});
        end
    endtask

    task automatic test_stall;
        int beat;
        int st;
        int n_stall;
        do_reset();
        start_seq();
        beat = 0;
        st = 0;
        n_stall = 0;
        for (int c = 0; c < 100 && beat < 6; c++) begin
            if (valid_v[0]) begin
                n_tests++;
                if ({out_v[0], idx_v[0]} !== {exp6[beat], 6'(6 - beat)}) begin
                    n_fail++;
                    $display("FAIL stall_beat %0d cycle %0d got out=%b idx=%0d expected out=%b idx=%0d",
                             beat, c, out_v[0], idx_v[0], exp6[beat], 6 - beat);
                end
                if ((beat == 0 || beat == 3) && st < 3) begin
                    rc_ready = 1'b0;
                    st++;
                    n_stall++;
                end else begin
                    rc_ready = 1'b1;
                    beat++;
                    st = 0;
                end
            end else begin
                rc_ready = 1'b0;
            end
            tick();
        end
        n_tests++;
        if (beat != 6 || n_stall != 6 || done_v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_complete got beats=%0d stalls=%0d done=%b expected beats=6 stalls=6 done=1",
                     beat, n_stall, done_v[0]);
        end
        rc_ready = 1'b1;
    endtask

    task automatic test_long;
        for (int x = 0; x < 64; x++) begin
            n_tests++;
            if (inv(fwd(6'(x))) !== 6'(x)) begin
                n_fail++;
                $display("FAIL model_inverse x=%0d got %0d expected %0d", x, inv(fwd(6'(x))), x);
            end
        end
        do_reset();
        start_seq();
        collect(1, 200);
        n_tests++;
        if (!cap_done || cap_first != 48 || cap_v.size() != 48) begin
            n_fail++;
            $display("FAIL long_shape got done=%b first=%0d beats=%0d expected done=1 first=48 beats=48",
                     cap_done, cap_first, cap_v.size());
        end
        for (int j = 0; j < cap_v.size() && j < 48; j++) begin
            n_tests++;
            if ({cap_v[j], cap_i[j], cap_l[j]} !== {model[48 - j], 6'(48 - j), j == 47}) begin
                n_fail++;
                $display("FAIL long_beat %0d got out=%b idx=%0d last=%b expected out=%b idx=%0d last=%b",
                         j, cap_v[j], cap_i[j], cap_l[j], model[48 - j], 48 - j, j == 47);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [27:0] rise_m;
        logic [27:0] done_m;
        logic [27:0] busy_m;
        logic        prev_v;
        do_reset();
        rc_ready = 1'b1;
        start = 1'b1;
        tick();
        rise_m = '0;
        done_m = '0;
        busy_m = '0;
        prev_v = 1'b0;
        for (int t = 0; t < 28; t++) begin
            rise_m[t] = valid_v[0] && !prev_v;
            done_m[t] = done_v[0];
            busy_m[t] = busy_v[0];
            prev_v = valid_v[0];
            if (t < 27) tick();
        end
        start = 1'b0;
        n_tests++;
        if (rise_m !== 28'h0100040) begin
            n_fail++;
            $display("FAIL b2b_valid_rise got %h expected 0100040", rise_m);
        end
        n_tests++;
        if (done_m !== 28'h4001000) begin
            n_fail++;
            $display("FAIL b2b_done got %h expected 4001000", done_m);
        end
        n_tests++;
        if (busy_m !== 28'h3FFCFFF) begin
            n_fail++;
            $display("FAIL b2b_busy got %h expected 3ffcfff", busy_m);
        end
    endtask

    task automatic test_reset_mid;
        logic found;
        do_reset();
        start_seq();
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_tests++;
        if ({busy_v[0], valid_v[0], last_v[0], done_v[0], out_v[0], idx_v[0]} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_seek got %h expected 0000",
                     {busy_v[0], valid_v[0], last_v[0], done_v[0], out_v[0], idx_v[0]});
        end
        start_seq();
        rc_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (valid_v[0] && idx_v[0] == 6'd3) found = 1'b1;
            else tick();
        end
        n_tests++;
        if (!found || out_v[0] !== exp6[3]) begin
            n_fail++;
            $display("FAIL reset_mid_reach got found=%b out=%b expected found=1 out=%b", found, out_v[0], exp6[3]);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_tests++;
        if ({busy_v[0], valid_v[0], last_v[0], done_v[0], out_v[0], idx_v[0]} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_emit got %h expected 0000",
                     {busy_v[0], valid_v[0], last_v[0], done_v[0], out_v[0], idx_v[0]});
        end
        start_seq();
        collect(0, 50);
        n_tests++;
        if (!cap_done || cap_first != 6 || cap_v.size() != 6) begin
            n_fail++;
            $display("FAIL reset_mid_rerun got done=%b first=%0d beats=%0d expected done=1 first=6 beats=6",
                     cap_done, cap_first, cap_v.size());
        end
        for (int j = 0; j < cap_v.size() && j < 6; j++) begin
            n_tests++;
            if (cap_v[j] !== exp6[j]) begin
                n_fail++;
                $display("FAIL reset_mid_beat %0d got %b expected %b", j, cap_v[j], exp6[j]);
            end
        end
    endtask

    task automatic test_bounds;
        logic saw_lock;
        do_reset();
        start_seq();
        collect(2, 20);
        n_tests++;
        if (!cap_done || cap_first != 1 || cap_v.size() != 1) begin
            n_fail++;
            $display("FAIL r1_shape got done=%b first=%0d beats=%0d expected done=1 first=1 beats=1",
                     cap_done, cap_first, cap_v.size());
        end else begin
            n_tests++;
            if ({cap_v[0], cap_i[0], cap_l[0]} !== {6'b000001, 6'd1, 1'b1}) begin
                n_fail++;
                $display("FAIL r1_beat got out=%b idx=%0d last=%b expected out=000001 idx=1 last=1",
                         cap_v[0], cap_i[0], cap_l[0]);
            end
        end
        do_reset();
        start_seq();
        collect(3, 200);
        n_tests++;
        if (!cap_done || cap_first != 63 || cap_v.size() != 63) begin
            n_fail++;
            $display("FAIL r63_shape got done=%b first=%0d beats=%0d expected done=1 first=63 beats=63",
                     cap_done, cap_first, cap_v.size());
        end else begin
            n_tests++;
            if (cap_v[0] !== model[63]) begin
                n_fail++;
                $display("FAIL r63_first got %b expected %b", cap_v[0], model[63]);
            end
        end
        saw_lock = 1'b0;
        foreach (cap_v[j]) if (cap_v[j] === 6'b111111) saw_lock = 1'b1;
        n_tests++;
        if (saw_lock !== 1'b0) begin
            n_fail++;
            $display("FAIL r63_lockup got 111111 in stream expected never");
        end
    endtask

    initial begin
        model[0] = 6'd0;
        for (int k = 1; k < 64; k++) model[k] = fwd(model[k - 1]);
        test_reset();
        test_stream();
        test_stall();
        test_long();
        test_back_to_back();
        test_reset_mid();
        test_bounds();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
